// File: rtl/membus_arbiter.sv
// Two-port (fetch/data) arbiter onto one MMIO bus, with a 2-entry in-order tracker that routes responses back.
// Optional macro MEMBUS_ARB_STARVE_GUARD_EN adds a fetch-starvation counter that forces a fetch grant.
module membus_arbiter #(
  parameter int XLEN         = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [XLEN-1:0]         i_addr,
  output logic                    i_rvalid,
  output logic [31:0]             i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [XLEN-1:0]         d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [XLEN-1:0]         m_addr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    proto_err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [1:0] count_q, count_d;
  logic       rdPtr_q, rdPtr_d;
  logic       wrPtr_q, wrPtr_d;
  logic [1:0] entSrc_q, entSrc_d;
  logic [1:0] entAddr2_q, entAddr2_d;
  logic       protoErr_q, protoErr_d;

  logic fifoFull, fifoEmpty;
  logic starveOverride, grantD, grantI;
  logic reqValid, accept, iAccept, pop;
  logic headSrc, headAddr2, pushAddr2;

  assign fifoFull  = (count_q == 2'd2);
  assign fifoEmpty = (count_q == 2'd0);

`ifdef MEMBUS_ARB_STARVE_GUARD_EN
  logic [CW-1:0] starveCnt_q, starveCnt_d;

  assign starveOverride = i_valid && (starveCnt_q == CW'(STARVE_LIMIT));

  // Counts cycles a fetch waits unserved; any gap in i_valid or a fetch accept restarts it.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!i_valid || iAccept) begin
      starveCnt_d = '0;
    end else if (!i_ready && (starveCnt_q != CW'(STARVE_LIMIT))) begin
      starveCnt_d = starveCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  assign starveOverride = 1'b0;
`endif

  assign grantD = d_valid & ~starveOverride;
  assign grantI = i_valid & ~grantD;

  // A full tracker blocks issue even when a response pops the same cycle.
  assign reqValid = rst & (i_valid | d_valid) & ~fifoFull;
  assign accept   = reqValid & m_ready;
  assign iAccept  = accept & grantI;

  assign m_valid = reqValid;
  assign i_ready = rst & m_ready & ~fifoFull & grantI;
  assign d_ready = rst & m_ready & ~fifoFull & grantD;

  assign m_addr    = grantD ? d_addr : i_addr;
  assign m_wen     = grantD & d_wen;
  assign m_wdata   = grantD ? d_wdata : '0;
  assign m_wmask   = grantD ? d_wmask : '0;
  assign pushAddr2 = grantD ? d_addr[2] : i_addr[2];

  assign headSrc   = entSrc_q[rdPtr_q];
  assign headAddr2 = entAddr2_q[rdPtr_q];
  assign pop       = rst & m_rvalid & ~fifoEmpty;

  assign i_rvalid = pop & ~headSrc;
  assign d_rvalid = pop & headSrc;
  assign i_rdata  = headAddr2 ? m_rdata[63:32] : m_rdata[31:0];
  assign d_rdata  = m_rdata;
  assign proto_err = protoErr_q;

  // Tracker entries record source (1 = data port) and address bit 2 for fetch word selection.
  always_comb begin
    entSrc_d   = entSrc_q;
    entAddr2_d = entAddr2_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    if (accept) begin
      entSrc_d[wrPtr_q]   = grantD;
      entAddr2_d[wrPtr_q] = pushAddr2;
      wrPtr_d             = ~wrPtr_q;
    end
    if (pop) begin
      rdPtr_d = ~rdPtr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    protoErr_d = protoErr_q | (m_rvalid & fifoEmpty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= 2'd0;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      entSrc_q   <= 2'b00;
      entAddr2_q <= 2'b00;
      protoErr_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      entSrc_q   <= entSrc_d;
      entAddr2_q <= entAddr2_d;
      protoErr_q <= protoErr_d;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: reset, routing, ordering, full blocking, starvation and protocol error.
// Expected starvation behaviour follows MEMBUS_ARB_STARVE_GUARD_EN when the bench is built with it.
module tb_membus_arbiter;

  localparam int XLEN = 64;
  localparam int DW   = 64;
  localparam int SL   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready, i_rvalid;
  logic [XLEN-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_valid, d_ready, d_wen, d_rvalid;
  logic [XLEN-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [DW/8-1:0] d_wmask;
  logic          m_valid, m_ready, m_wen, m_rvalid;
  logic [XLEN-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wmask;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;
  int firstI;
  int expFirst;

  always #5 clk = ~clk;

  membus_arbiter #(.XLEN(XLEN), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .proto_err(proto_err)
  );

  // Drives one cycle's worth of requester and bus inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic [63:0] ia, input logic dv,
                               input logic [63:0] da, input logic dw, input logic mrv,
                               input logic [63:0] mrd);
    i_valid  = iv;
    i_addr   = ia;
    d_valid  = dv;
    d_addr   = da;
    d_wen    = dw;
    m_rvalid = mrv;
    m_rdata  = mrd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    m_ready = 1'b1;
    d_wdata = 64'h0;
    d_wmask = 8'h0;
    @(negedge clk);

    // Reset forces handshakes and responses low regardless of inputs
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 64'h100, 1'b0, 1'b1, 64'h0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_i_ready", 64'(i_ready), 64'd0);
    checkOutput("rst_d_ready", 64'(d_ready), 64'd0);
    checkOutput("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    checkOutput("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    nextCycle();
    nextCycle();
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);

    // Fetch from upper word
    rst = 1'b1;
    applyStimulus(1'b1, 64'h8000_0004, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("f_m_valid", 64'(m_valid), 64'd1);
    checkOutput("f_i_ready", 64'(i_ready), 64'd1);
    checkOutput("f_m_addr", m_addr, 64'h8000_0004);
    checkOutput("f_m_wen", 64'(m_wen), 64'd0);
    checkOutput("f_m_wmask", 64'(m_wmask), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    checkOutput("f_i_rvalid", 64'(i_rvalid), 64'd1);
    checkOutput("f_i_rdata", 64'(i_rdata), 64'h1111_2222);
    checkOutput("f_d_rvalid", 64'(d_rvalid), 64'd0);
    nextCycle();

    // Simultaneous requests: data wins
    d_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    d_wmask = 8'hF0;
    applyStimulus(1'b1, 64'h200, 1'b1, 64'h100, 1'b1, 1'b0, 64'h0);
    checkOutput("pri_m_addr", m_addr, 64'h100);
    checkOutput("pri_m_wen", 64'(m_wen), 64'd1);
    checkOutput("pri_d_ready", 64'(d_ready), 64'd1);
    checkOutput("pri_i_ready", 64'(i_ready), 64'd0);
    checkOutput("pri_m_wdata", m_wdata, 64'hDEAD_BEEF_0BAD_F00D);
    checkOutput("pri_m_wmask", 64'(m_wmask), 64'hF0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checkOutput("pri_d_rvalid", 64'(d_rvalid), 64'd1);
    checkOutput("pri_i_rvalid", 64'(i_rvalid), 64'd0);
    nextCycle();

    // Two outstanding (D read, then fetch with addr[2]=0); tracker full blocks issue
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h40, 1'b0, 1'b0, 64'h0);
    checkOutput("ord_d_ready", 64'(d_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("ord_i_ready", 64'(i_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 64'h8000_0008, 1'b1, 64'h48, 1'b0, 1'b0, 64'h0);
    checkOutput("full_m_valid", 64'(m_valid), 64'd0);
    checkOutput("full_i_ready", 64'(i_ready), 64'd0);
    checkOutput("full_d_ready", 64'(d_ready), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 64'h8000_0008, 1'b1, 64'h48, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("ord_d_rvalid", 64'(d_rvalid), 64'd1);
    checkOutput("ord_d_rdata", d_rdata, 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("ord_i_rvalid0", 64'(i_rvalid), 64'd0);
    checkOutput("fullpop_m_valid", 64'(m_valid), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 64'h8000_0008, 1'b1, 64'h48, 1'b0, 1'b1, 64'hBBBB_BBBB_1234_5678);
    checkOutput("ord_i_rvalid", 64'(i_rvalid), 64'd1);
    checkOutput("ord_i_rdata", 64'(i_rdata), 64'h1234_5678);
    checkOutput("resume_m_valid", 64'(m_valid), 64'd1);
    checkOutput("resume_d_ready", 64'(d_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checkOutput("drain_d_rvalid", 64'(d_rvalid), 64'd1);
    nextCycle();

    // Fetch starvation under continuous data traffic
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
    expFirst = SL;
`else
    expFirst = -1;
`endif
    firstI = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h80, 1'b0, (i > 0), 64'h0);
      if (m_valid && i_ready && firstI < 0) firstI = i;
      nextCycle();
    end
    checkOutput("starve_first_i", 64'(firstI), 64'(expFirst));
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    nextCycle();

    // Stray response with empty tracker
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checkOutput("stray_i_rvalid", 64'(i_rvalid), 64'd0);
    checkOutput("stray_d_rvalid", 64'(d_rvalid), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("stray_proto_err", 64'(proto_err), 64'd1);
    nextCycle();
    checkOutput("sticky_proto_err", 64'(proto_err), 64'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8, 1'b0, 1'b0, 64'h0);
    checkOutput("rst2_m_valid", 64'(m_valid), 64'd0);
    nextCycle();
    checkOutput("rst2_proto_err", 64'(proto_err), 64'd0);

    // Reset with a request outstanding discards it
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8, 1'b0, 1'b0, 64'h0);
    checkOutput("mid_d_ready", 64'(d_ready), 64'd1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h0);
    checkOutput("mid_d_rvalid", 64'(d_rvalid), 64'd0);
    checkOutput("mid_i_rvalid", 64'(i_rvalid), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("mid_proto_err", 64'(proto_err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
